// File: rtl/cvo_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cvo_cfg_pkg
//  Purpose  : Shared types, register offsets, limits and the video-mode
//             register table for the CVO configuration sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package cvo_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STOP   = 3'd1,
    ST_POLL   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_ENABLE = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [8:0] CTRL_OFFSET   = 9'd0;
  localparam logic [8:0] STATUS_OFFSET = 9'd1;
  localparam int         N_ENTRIES     = 16;
  localparam int         UF_LIMIT      = 1023;
  localparam int         POLL_LIMIT    = 4095;

  // Timing registers written during LOAD; the same register map for every mode.
  localparam logic [8:0] ENTRY_ADDR [N_ENTRIES] = '{
    9'h004, 9'h005, 9'h006, 9'h007, 9'h008, 9'h009, 9'h00A, 9'h00B,
    9'h00C, 9'h00D, 9'h00E, 9'h00F, 9'h010, 9'h011, 9'h012, 9'h013
  };

  // Per mode: width, height, hsync, hfp, hbp, vsync, vfp, vbp, total width,
  // total height, hsync pol, vsync pol, interlaced, samples, lines, valid.
  localparam logic [31:0] MODE_TABLE [4][N_ENTRIES] = '{
    '{640,  480,  96,  16,  48, 2, 10, 33,  800,  525, 0, 0, 0,  640,  480, 1},
    '{800,  600, 128,  40,  88, 4,  1, 23, 1056,  628, 1, 1, 0,  800,  600, 1},
    '{1280, 720,  40, 110, 220, 5,  5, 20, 1650,  750, 1, 1, 0, 1280,  720, 1},
    '{1920,1080,  44,  88, 148, 5,  4, 36, 2200, 1125, 1, 1, 0, 1920, 1080, 1}
  };

endpackage
`default_nettype wire

// File: rtl/cvo_mode_rom.sv
`default_nettype none
// ============================================================================
//  Module   : cvo_mode_rom
//  Purpose  : Combinational lookup of (mode, entry index) -> register
//             address and data from the mode table.
//  Revision : 1.0  initial release
// ============================================================================
module cvo_mode_rom
  import cvo_cfg_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [3:0]  index,
  output logic [8:0]  address,
  output logic [31:0] data
);

  assign address = ENTRY_ADDR[index];
  assign data    = MODE_TABLE[mode][index];

endmodule
`default_nettype wire

// File: rtl/cvo_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cvo_config_sequencer
//  Purpose  : Drives the CVO control slave: stop, wait for idle, load a preset
//             mode, enable, then supervise underflow and auto-restart.
//  Revision : 1.0  initial release
// ============================================================================
module cvo_config_sequencer
  import cvo_cfg_pkg::*;
#(
  parameter int UF_THRESHOLD = UF_LIMIT
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cfg_start,
  input  logic [1:0]  cfg_mode_sel,
  input  logic        vid_underflow,
  output logic [8:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  restart_cnt
);

  localparam logic [9:0]  UF_LAST    = 10'(UF_THRESHOLD - 1);
  localparam logic [11:0] POLL_LAST  = 12'(POLL_LIMIT);
  localparam logic [3:0]  ENTRY_LAST = 4'(N_ENTRIES - 1);

  state_t      state, state_nxt;
  logic [1:0]  mode_lat;
  logic [3:0]  entry_idx;
  logic [11:0] poll_cnt;
  logic [9:0]  uf_cnt;
  logic        start_accept;
  logic        uf_restart;
  logic        xfer_done;
  logic [8:0]  rom_address;
  logic [31:0] rom_data;
  logic        readdata_unused;

  // Only STATUS bit0 matters; the other bits are deliberately ignored.
  assign readdata_unused = ^avm_readdata[31:1];
  assign xfer_done       = (avm_write | avm_read) & ~avm_waitrequest;

  assign cfg_busy  = (state == ST_STOP) || (state == ST_POLL) ||
                     (state == ST_LOAD) || (state == ST_ENABLE);
  assign cfg_done  = (state == ST_RUN);
  assign cfg_error = (state == ST_ERR);

  cvo_mode_rom u_rom (
    .mode    (mode_lat),
    .index   (entry_idx),
    .address (rom_address),
    .data    (rom_data)
  );

  // State register; reset drops to IDLE at once, aborting any transfer.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Next state and bus strobes; strobes depend only on state so they hold
  // steady across waitrequest stalls.
  always_comb begin
    state_nxt     = state;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = 9'd0;
    avm_writedata = 32'd0;
    start_accept  = 1'b0;
    uf_restart    = 1'b0;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (cfg_start) begin
          state_nxt    = ST_STOP;
          start_accept = 1'b1;
        end
      end
      ST_STOP: begin
        avm_write   = 1'b1;
        avm_address = CTRL_OFFSET;
        if (!avm_waitrequest) state_nxt = ST_POLL;
      end
      ST_POLL: begin
        avm_read    = 1'b1;
        avm_address = STATUS_OFFSET;
        if (!avm_waitrequest) begin
          if (!avm_readdata[0])          state_nxt = ST_LOAD;
          else if (poll_cnt == POLL_LAST) state_nxt = ST_ERR;
        end
      end
      ST_LOAD: begin
        avm_write     = 1'b1;
        avm_address   = rom_address;
        avm_writedata = rom_data;
        if (!avm_waitrequest && entry_idx == ENTRY_LAST) state_nxt = ST_ENABLE;
      end
      ST_ENABLE: begin
        avm_write     = 1'b1;
        avm_address   = CTRL_OFFSET;
        avm_writedata = 32'd1;
        if (!avm_waitrequest) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A user restart takes priority over an underflow restart.
        if (cfg_start) begin
          state_nxt    = ST_STOP;
          start_accept = 1'b1;
        end else if (vid_underflow && uf_cnt == UF_LAST) begin
          state_nxt  = ST_STOP;
          uf_restart = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Mode latch, table index, poll counter, underflow run length, restarts.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mode_lat    <= 2'd0;
      entry_idx   <= 4'd0;
      poll_cnt    <= 12'd0;
      uf_cnt      <= 10'd0;
      restart_cnt <= 8'd0;
    end else begin
      if (start_accept) mode_lat <= cfg_mode_sel;

      if (state != ST_LOAD) entry_idx <= 4'd0;
      else if (xfer_done)   entry_idx <= entry_idx + 4'd1;

      if (state != ST_POLL)
        poll_cnt <= 12'd0;
      else if (xfer_done && avm_readdata[0] && poll_cnt != POLL_LAST)
        poll_cnt <= poll_cnt + 12'd1;

      if (state == ST_RUN && state_nxt == ST_RUN && vid_underflow)
        uf_cnt <= uf_cnt + 10'd1;
      else
        uf_cnt <= 10'd0;

      if (uf_restart && restart_cnt != 8'hFF) restart_cnt <= restart_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cvo_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cvo_config_sequencer
//  Purpose  : Directed self-checking bench for cvo_config_sequencer with an
//             Avalon slave model that stalls, logs transfers and answers
//             STATUS reads.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cvo_config_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [1:0]  cfg_mode_sel = 2'd0;
  logic        vid_underflow = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;
  logic [8:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic        cfg_busy, cfg_done, cfg_error;
  logic [7:0]  restart_cnt;

  // Second instance with a short underflow threshold for the saturation run.
  logic        start2 = 1'b0;
  logic        uf2 = 1'b0;
  logic [1:0]  mode2 = 2'd0;
  logic [31:0] rdata2 = 32'd0;
  logic        wait2 = 1'b0;
  logic [8:0]  addr2;
  logic        wr2, rd2, busy2, done2, err2;
  logic [31:0] wdata2;
  logic [7:0]  rcnt2;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave model state
  logic [41:0] log_q[$];
  logic [42:0] held;
  bit          in_xfer = 0;
  bit          force_wait = 0;
  bit          status_stuck = 0;
  int unsigned stall_max = 0;
  int          stall_left = 0;
  int          status_busy_left = 0;
  int          n_reads = 0;
  int          stab_err = 0;
  int          both_err = 0;

  logic [31:0] m1 [16] = '{800, 600, 128, 40, 88, 4, 1, 23, 1056, 628, 1, 1, 0, 800, 600, 1};
  logic [31:0] m2 [16] = '{1280, 720, 40, 110, 220, 5, 5, 20, 1650, 750, 1, 1, 0, 1280, 720, 1};

  always #5 clk = ~clk;

  cvo_config_sequencer dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .cfg_start(cfg_start),
    .cfg_mode_sel(cfg_mode_sel), .vid_underflow(vid_underflow),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .restart_cnt(restart_cnt)
  );

  cvo_config_sequencer #(.UF_THRESHOLD(4)) dut_sat (
    .clk_clk(clk), .reset_reset_n(rst_n), .cfg_start(start2),
    .cfg_mode_sel(mode2), .vid_underflow(uf2),
    .avm_address(addr2), .avm_write(wr2), .avm_read(rd2),
    .avm_writedata(wdata2), .avm_readdata(rdata2),
    .avm_waitrequest(wait2), .cfg_busy(busy2),
    .cfg_done(done2), .cfg_error(err2), .restart_cnt(rcnt2)
  );

  // Avalon slave: decides waitrequest shortly after each edge, then logs the
  // transfer if it completes in this cycle.
  always begin
    @(posedge clk);
    #2;
    if (avm_write && avm_read) both_err++;
    if (avm_write || avm_read) begin
      if (!in_xfer) begin
        in_xfer    = 1;
        held       = {avm_write, avm_read, avm_address, avm_writedata};
        stall_left = int'($urandom_range(stall_max, 0));
      end else if ({avm_write, avm_read, avm_address, avm_writedata} !== held) begin
        stab_err++;
      end
      avm_waitrequest = force_wait || (stall_left > 0);
      if (stall_left > 0) stall_left--;
      avm_readdata = {31'd0, status_stuck || (status_busy_left > 0)};
    end else begin
      in_xfer         = 0;
      avm_waitrequest = force_wait;
      avm_readdata    = 32'd0;
    end
    #2;
    if ((avm_write || avm_read) && !avm_waitrequest) begin
      log_q.push_back({avm_write, avm_address, avm_write ? avm_writedata : 32'd0});
      if (avm_read) begin
        n_reads++;
        if (avm_readdata[0] && status_busy_left > 0) status_busy_left--;
      end
      in_xfer = 0;
    end
  end

  function automatic logic [31:0] tbl(input int mode, input int i);
    return (mode == 1) ? m1[i] : m2[i];
  endfunction

  // Number of logged transfers differing from the expected programming order.
  function automatic int seq_errors(input int mode, input int nreads);
    int n_exp = nreads + 18;
    int errs = 0;
    logic [41:0] exp_e;
    if (log_q.size() != n_exp) errs++;
    for (int k = 0; k < n_exp && k < log_q.size(); k++) begin
      if (k == 0)                exp_e = {1'b1, 9'd0, 32'd0};
      else if (k <= nreads)      exp_e = {1'b0, 9'd1, 32'd0};
      else if (k <= nreads + 16) exp_e = {1'b1, 9'(4 + k - nreads - 1), tbl(mode, k - nreads - 1)};
      else                       exp_e = {1'b1, 9'd0, 32'd1};
      if (log_q[k] !== exp_e) errs++;
    end
    return errs;
  endfunction

  task automatic kick(input logic [1:0] mode);
    @(negedge clk);
    cfg_start    = 1'b1;
    cfg_mode_sel = mode;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_flag(input int budget, output int cycles);
    cycles = 0;
    while (!(cfg_done || cfg_error) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({avm_write, avm_read, avm_address, avm_writedata} !== 43'd0) begin
      n_fail++; $display("FAIL reset_bus: got %h want 0", {avm_write, avm_read, avm_address, avm_writedata});
    end
    n_cmp++;
    if ({cfg_busy, cfg_done, cfg_error, restart_cnt} !== 11'd0) begin
      n_fail++; $display("FAIL reset_status: got %h want 0", {cfg_busy, cfg_done, cfg_error, restart_cnt});
    end
    rst_n = 1'b1;
    log_q.delete();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (log_q.size() != 0 || cfg_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: transfers=%0d busy=%b want 0/0", log_q.size(), cfg_busy);
    end
  endtask

  task automatic test_mode2_basic;
    int c, e;
    log_q.delete(); stall_max = 0; status_busy_left = 0;
    kick(2'd2);
    cfg_mode_sel = 2'd3;
    n_cmp++;
    if (!(avm_write === 1'b1 && avm_address === 9'd0 && avm_writedata === 32'd0 && cfg_busy === 1'b1)) begin
      n_fail++; $display("FAIL first_write: wr=%b addr=%h data=%h busy=%b want 1/0/0/1", avm_write, avm_address, avm_writedata, cfg_busy);
    end
    wait_flag(60, c);
    n_cmp++;
    if (c + 1 !== 20 || cfg_done !== 1'b1) begin
      n_fail++; $display("FAIL done_cycle: got cycle %0d done=%b want 20/1", c + 1, cfg_done);
    end
    e = seq_errors(2, 1);
    n_cmp++;
    if (e !== 0) begin
      n_fail++; $display("FAIL seq_mode2: bad entries %0d want 0 (logged %0d)", e, log_q.size());
    end
    n_cmp++;
    if (cfg_busy !== 1'b0 || cfg_error !== 1'b0 || restart_cnt !== 8'd0) begin
      n_fail++; $display("FAIL run_status: busy=%b err=%b rc=%0d want 0/0/0", cfg_busy, cfg_error, restart_cnt);
    end
  endtask

  task automatic test_start_ignored;
    int c, e;
    log_q.delete();
    kick(2'd2);
    cfg_start = 1'b1; cfg_mode_sel = 2'd1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    cfg_start = 1'b1; cfg_mode_sel = 2'd3;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_flag(60, c);
    n_cmp++;
    if (c + 6 !== 20) begin
      n_fail++; $display("FAIL busy_start_timing: done at cycle %0d want 20", c + 6);
    end
    e = seq_errors(2, 1);
    n_cmp++;
    if (e !== 0) begin
      n_fail++; $display("FAIL busy_start_mode: bad entries %0d want 0 (logged %0d)", e, log_q.size());
    end
  endtask

  task automatic test_stalls;
    int c, e;
    log_q.delete(); stall_max = 5; status_busy_left = 3; n_reads = 0; stab_err = 0; both_err = 0;
    kick(2'd1);
    wait_flag(400, c);
    stall_max = 0;
    n_cmp++;
    if (cfg_done !== 1'b1) begin
      n_fail++; $display("FAIL stall_done: done=%b want 1 after %0d cycles", cfg_done, c);
    end
    e = seq_errors(1, 4);
    n_cmp++;
    if (e !== 0 || n_reads !== 4) begin
      n_fail++; $display("FAIL stall_seq: bad entries %0d reads %0d want 0/4", e, n_reads);
    end
    n_cmp++;
    if (stab_err !== 0 || both_err !== 0) begin
      n_fail++; $display("FAIL stall_stable: unstable=%0d dual_strobe=%0d want 0/0", stab_err, both_err);
    end
  endtask

  task automatic test_underflow;
    int c, e;
    log_q.delete();
    vid_underflow = 1'b1;
    repeat (1022) @(negedge clk);
    vid_underflow = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (restart_cnt !== 8'd0 || cfg_done !== 1'b1 || log_q.size() != 0) begin
      n_fail++; $display("FAIL uf_1022: rc=%0d done=%b transfers=%0d want 0/1/0", restart_cnt, cfg_done, log_q.size());
    end
    vid_underflow = 1'b1;
    repeat (1023) @(negedge clk);
    n_cmp++;
    if (restart_cnt !== 8'd1 || cfg_busy !== 1'b1 || avm_write !== 1'b1 || avm_address !== 9'd0) begin
      n_fail++; $display("FAIL uf_1023: rc=%0d busy=%b wr=%b addr=%h want 1/1/1/0", restart_cnt, cfg_busy, avm_write, avm_address);
    end
    wait_flag(60, c);
    e = seq_errors(1, 1);
    n_cmp++;
    if (c !== 19 || e !== 0) begin
      n_fail++; $display("FAIL uf_resequence: cycles %0d bad entries %0d want 19/0", c, e);
    end
    repeat (1010) @(negedge clk);
    vid_underflow = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (restart_cnt !== 8'd1 || cfg_done !== 1'b1) begin
      n_fail++; $display("FAIL uf_outside_run: rc=%0d done=%b want 1/1", restart_cnt, cfg_done);
    end
  endtask

  task automatic test_start_vs_underflow;
    int c, e;
    log_q.delete();
    vid_underflow = 1'b1;
    repeat (1022) @(negedge clk);
    cfg_start = 1'b1; cfg_mode_sel = 2'd2;
    @(negedge clk);
    cfg_start = 1'b0; vid_underflow = 1'b0;
    n_cmp++;
    if (restart_cnt !== 8'd1 || cfg_busy !== 1'b1) begin
      n_fail++; $display("FAIL start_wins: rc=%0d busy=%b want 1/1", restart_cnt, cfg_busy);
    end
    wait_flag(60, c);
    e = seq_errors(2, 1);
    n_cmp++;
    if (c !== 19 || e !== 0) begin
      n_fail++; $display("FAIL start_wins_mode: cycles %0d bad entries %0d want 19/0", c, e);
    end
  endtask

  task automatic test_poll_timeout;
    int c, e, sz;
    log_q.delete(); n_reads = 0; status_stuck = 1;
    kick(2'd2);
    wait_flag(5000, c);
    n_cmp++;
    if (cfg_error !== 1'b1 || cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
      n_fail++; $display("FAIL poll_err: err=%b busy=%b done=%b want 1/0/0", cfg_error, cfg_busy, cfg_done);
    end
    n_cmp++;
    if (n_reads !== 4096) begin
      n_fail++; $display("FAIL poll_reads: got %0d want 4096", n_reads);
    end
    status_stuck = 0;
    sz = log_q.size();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (log_q.size() != sz || avm_write !== 1'b0 || avm_read !== 1'b0) begin
      n_fail++; $display("FAIL err_idle: new transfers %0d wr=%b rd=%b want 0/0/0", log_q.size() - sz, avm_write, avm_read);
    end
    log_q.delete();
    kick(2'd1);
    n_cmp++;
    if (cfg_error !== 1'b0 || avm_write !== 1'b1 || avm_address !== 9'd0) begin
      n_fail++; $display("FAIL err_restart: err=%b wr=%b addr=%h want 0/1/0", cfg_error, avm_write, avm_address);
    end
    wait_flag(60, c);
    e = seq_errors(1, 1);
    n_cmp++;
    if (c !== 19 || e !== 0) begin
      n_fail++; $display("FAIL err_reseq: cycles %0d bad entries %0d want 19/0", c, e);
    end
  endtask

  task automatic test_reset_mid_load;
    kick(2'd2);
    repeat (8) @(negedge clk);
    force_wait = 1;
    @(negedge clk);
    n_cmp++;
    if (avm_write !== 1'b1 || avm_address !== 9'h00B || avm_writedata !== 32'd20 || avm_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL load_entry7: wr=%b addr=%h data=%0d wait=%b want 1/00b/20/1", avm_write, avm_address, avm_writedata, avm_waitrequest);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({avm_write, avm_read, avm_address, avm_writedata, cfg_busy, cfg_done, cfg_error, restart_cnt} !== 54'd0) begin
      n_fail++; $display("FAIL async_reset: wr=%b rd=%b addr=%h data=%h busy=%b done=%b err=%b rc=%0d want all 0",
                         avm_write, avm_read, avm_address, avm_writedata, cfg_busy, cfg_done, cfg_error, restart_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; force_wait = 0;
    log_q.delete();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (log_q.size() != 0 || cfg_busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: transfers=%0d busy=%b want 0/0", log_q.size(), cfg_busy);
    end
  endtask

  task automatic test_saturate;
    @(negedge clk);
    start2 = 1'b1; mode2 = 2'd0;
    @(negedge clk);
    start2 = 1'b0; uf2 = 1'b1;
    repeat (7200) @(negedge clk);
    uf2 = 1'b0;
    n_cmp++;
    if (rcnt2 !== 8'd255) begin
      n_fail++; $display("FAIL restart_saturate: got %0d want 255", rcnt2);
    end
  endtask

  initial begin
    test_reset();
    test_mode2_basic();
    test_start_ignored();
    test_stalls();
    test_underflow();
    test_start_vs_underflow();
    test_poll_timeout();
    test_reset_mid_load();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
